// File: rtl/vec_lsu_pkg.sv
// Shared types and helpers for the vector load sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vec_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WB,
    S_ERR
  } vls_state_e;

  localparam logic [2:0] VSEW_E8  = 3'b000;
  localparam logic [2:0] VSEW_E16 = 3'b001;
  localparam logic [2:0] VSEW_E32 = 3'b010;

  // Element width in bits; 0 marks an encoding this block does not support.
  function automatic int unsigned sew_bits(input logic [2:0] vsew);
    case (vsew)
      VSEW_E8:  return 8;
      VSEW_E16: return 16;
      VSEW_E32: return 32;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/vec_load_buffer.sv
// VLEN-bit staging register assembled one SEW-wide element at a time.
// Latency: an element written at edge N is visible on q after edge N.
// Backpressure: none; accepts a write every cycle, clear has priority.
module vec_load_buffer #(
  parameter int VLEN = 512
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      wr,
  input  logic [$clog2(VLEN/8)-1:0] idx,
  input  logic [1:0]                sew,
  input  logic [31:0]               elem,
  output logic [VLEN-1:0]           q
);

  localparam int NB = VLEN / 8;
  localparam int IW = $clog2(NB);

  // Byte lane of the element word feeding a buffer byte: e8 uses lane 0,
  // e16 alternates lanes 0/1, e32 cycles through lanes 0..3.
  logic [1:0] lane_mask;
  assign lane_mask = (sew == 2'd2) ? 2'b11 : ((sew == 2'd1) ? 2'b01 : 2'b00);

  logic [7:0] bytes [NB];

  for (genvar g = 0; g < NB; g++) begin : g_byte
    localparam logic [IW-1:0] BI = IW'(g);
    logic [1:0] lane;
    logic [7:0] lane_byte;
    assign lane = BI[1:0] & lane_mask;
    assign lane_byte = (lane == 2'd0) ? elem[7:0]   :
                       (lane == 2'd1) ? elem[15:8]  :
                       (lane == 2'd2) ? elem[23:16] : elem[31:24];

    // Zero on clear (tail stays zero-filled); load when this byte belongs to element idx.
    always_ff @(posedge clk) begin
      if (clr) begin
        bytes[g] <= '0;
      end else if (wr && ((BI >> sew) == idx)) begin
        bytes[g] <= lane_byte;
      end
    end

    assign q[g*8 +: 8] = bytes[g];
  end

endmodule

// File: rtl/vec_load_sequencer.sv
// Turns one unit-stride/strided vector load into per-element memory requests and one VRF write.
// Latency: first request the cycle after accept; VRF write the cycle after the last response.
// Backpressure: ld_ready only in IDLE; requests stall on mem_req_ready or MAX_OUTSTANDING in flight.
module vec_load_sequencer
  import vec_lsu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int VLEN            = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic                    ld_strided,
  input  logic [XLEN-1:0]         ld_base,
  input  logic [XLEN-1:0]         ld_stride,
  input  logic [$clog2(VLEN/8):0] ld_vl,
  input  logic [2:0]              ld_vsew,
  input  logic [4:0]              ld_vd,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [XLEN-1:0]         mem_req_addr,
  output logic [1:0]              mem_req_size,
  input  logic                    mem_rsp_valid,
  input  logic [XLEN-1:0]         mem_rsp_data,
  output logic                    vrf_wr_en,
  output logic [4:0]              vrf_wr_addr,
  output logic [VLEN-1:0]         vrf_wr_data,
  output logic                    ld_done,
  output logic                    ld_error
);

  localparam int VLW = $clog2(VLEN/8) + 1;
  localparam int IW  = $clog2(VLEN/8);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  function automatic int unsigned vlmax(input logic [2:0] vsew);
    return (sew_bits(vsew) == 0) ? 0 : VLEN / sew_bits(vsew);
  endfunction

  vls_state_e      state, state_nxt;
  logic            strided_q;
  logic [XLEN-1:0] stride_q, addr_q, step;
  logic [VLW-1:0]  vl_q, issue_cnt, rsp_cnt, issue_nxt, rsp_nxt;
  logic [2:0]      vsew_q;
  logic [4:0]      vd_q;
  logic [OW-1:0]   outstanding;
  logic            accept, cmd_err, req_can, req_fire, rsp_fire;

  assign accept   = (state == S_IDLE) && ld_valid;
  assign cmd_err  = (sew_bits(ld_vsew) == 0) || (32'(ld_vl) > vlmax(ld_vsew));
  assign req_can  = (state == S_ISSUE) && (outstanding < OW'(MAX_OUTSTANDING));
  assign req_fire = req_can && mem_req_ready;
  // Responses outside an active load are stale (e.g. abandoned by reset) and dropped.
  assign rsp_fire = mem_rsp_valid && ((state == S_ISSUE) || (state == S_DRAIN));
  assign issue_nxt = issue_cnt + VLW'(req_fire);
  assign rsp_nxt   = rsp_cnt + VLW'(rsp_fire);
  assign step      = strided_q ? stride_q : XLEN'(sew_bits(vsew_q) / 8);

  assign mem_req_valid = req_can;
  assign mem_req_addr  = addr_q;
  assign mem_req_size  = vsew_q[1:0];
  assign vrf_wr_addr   = vd_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and state-decoded strobes; a response landing with the last
  // issue skips DRAIN so the minimum-latency load writes back immediately.
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    vrf_wr_en = 1'b0;
    ld_done   = 1'b0;
    ld_error  = 1'b0;
    case (state)
      S_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (cmd_err)            state_nxt = S_ERR;
          else if (ld_vl == '0)   state_nxt = S_WB;
          else                    state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_fire && (issue_nxt == vl_q))
          state_nxt = (rsp_nxt == vl_q) ? S_WB : S_DRAIN;
      end
      S_DRAIN: begin
        if (rsp_nxt == vl_q) state_nxt = S_WB;
      end
      S_WB: begin
        ld_done   = 1'b1;
        vrf_wr_en = (vl_q != '0);
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        ld_done   = 1'b1;
        ld_error  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, address accumulator and the issue/response/in-flight counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      strided_q   <= 1'b0;
      stride_q    <= '0;
      addr_q      <= '0;
      vl_q        <= '0;
      vsew_q      <= '0;
      vd_q        <= '0;
      issue_cnt   <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
    end else if (accept) begin
      strided_q   <= ld_strided;
      stride_q    <= ld_stride;
      addr_q      <= ld_base;
      vl_q        <= ld_vl;
      vsew_q      <= ld_vsew;
      vd_q        <= ld_vd;
      issue_cnt   <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (req_fire) addr_q <= addr_q + step;
      issue_cnt <= issue_nxt;
      rsp_cnt   <= rsp_nxt;
      case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  vec_load_buffer #(.VLEN(VLEN)) u_buf (
    .clk  (clk),
    .clr  (reset || accept),
    .wr   (rsp_fire),
    .idx  (rsp_cnt[IW-1:0]),
    .sew  (vsew_q[1:0]),
    .elem (mem_rsp_data[31:0]),
    .q    (vrf_wr_data)
  );

endmodule

// File: tb/tb_vec_load_sequencer.sv
// Scoreboard bench for vec_load_sequencer: reference model predicts request
// addresses, the assembled register and completion status per command.
module tb_vec_load_sequencer;
  localparam int VLEN = 512;
  localparam int VLW  = 7;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic            ld_strided = 1'b0;
  logic [31:0]     ld_base = '0;
  logic [31:0]     ld_stride = '0;
  logic [VLW-1:0]  ld_vl = '0;
  logic [2:0]      ld_vsew = '0;
  logic [4:0]      ld_vd = '0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [31:0]     mem_req_addr;
  logic [1:0]      mem_req_size;
  logic            mem_rsp_valid = 1'b0;
  logic [31:0]     mem_rsp_data = '0;
  logic            vrf_wr_en;
  logic [4:0]      vrf_wr_addr;
  logic [VLEN-1:0] vrf_wr_data;
  logic            ld_done;
  logic            ld_error;

  vec_load_sequencer #(.XLEN(32), .VLEN(VLEN), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_strided(ld_strided),
    .ld_base(ld_base), .ld_stride(ld_stride), .ld_vl(ld_vl),
    .ld_vsew(ld_vsew), .ld_vd(ld_vd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .vrf_wr_en(vrf_wr_en), .vrf_wr_addr(vrf_wr_addr), .vrf_wr_data(vrf_wr_data),
    .ld_done(ld_done), .ld_error(ld_error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [1:0] size; } req_t;
  typedef struct packed { logic [4:0] vd; logic [VLEN-1:0] data; } wr_t;

  req_t        exp_req[$];
  wr_t         exp_wr[$];
  bit          exp_done[$];
  logic [31:0] rsp_data_q[$];
  int          due_q[$];

  int cyc = 0;
  int tests = 0, fails = 0;
  int lat = 1, rdy_pct = 100;
  bit lat0_hit = 1'b0;
  int hs_cnt = 0, inflight = 0, max_inflight = 0, done_cnt = 0, last_done_cyc = 0;
  req_t mr;
  wr_t  mw;
  bit   md;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: in-order responses 'lat' cycles after each handshake (lat 0 = same cycle).
  always begin
    @(posedge clk); #1;
    mem_req_ready = ($urandom_range(99) < 32'(rdy_pct));
    mem_rsp_valid = 1'b0;
    lat0_hit = 1'b0;
    if (due_q.size() != 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      mem_rsp_valid = 1'b1;
      mem_rsp_data = (rsp_data_q.size() != 0) ? rsp_data_q.pop_front() : $urandom;
    end else if (lat == 0 && mem_req_valid && mem_req_ready && !reset) begin
      lat0_hit = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = (rsp_data_q.size() != 0) ? rsp_data_q.pop_front() : $urandom;
    end
  end

  always @(negedge clk)
    if (!reset && mem_req_valid && mem_req_ready && !lat0_hit) due_q.push_back(cyc + lat);

  // Monitor: pops expectations whenever the DUT presents a request, write or completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        hs_cnt++;
        inflight++;
        check("req_expected", exp_req.size() != 0, 1);
        if (exp_req.size() != 0) begin
          mr = exp_req.pop_front();
          check("req_addr", mem_req_addr, mr.addr);
          check("req_size", mem_req_size, mr.size);
        end
      end
      if (mem_rsp_valid) inflight--;
      if (inflight > max_inflight) max_inflight = inflight;
      if (vrf_wr_en) begin
        check("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          mw = exp_wr.pop_front();
          check("wr_addr", vrf_wr_addr, mw.vd);
          check("wr_data", vrf_wr_data, mw.data);
        end
      end
      if (ld_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("ready_low_at_done", ld_ready, 0);
        check("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          md = exp_done.pop_front();
          check("ld_error", ld_error, md);
        end
      end
    end
  end

  // Reference model: element i lives at base + i*step and lands in bits [i*SEW +: SEW].
  task automatic expect_cmd(input bit strided, input logic [31:0] base, input logic [31:0] stride,
                            input int vl, input logic [2:0] vsew, input logic [4:0] vd);
    int sew;
    bit legal;
    logic [31:0] step, elem;
    logic [VLEN-1:0] expd;
    req_t r;
    wr_t w;
    sew = 8 << vsew;
    legal = (vsew <= 3'd2) && (vl <= VLEN / sew);
    if (!legal) begin
      exp_done.push_back(1'b1);
    end else begin
      step = strided ? stride : 32'(sew / 8);
      expd = '0;
      for (int i = 0; i < vl; i++) begin
        r.addr = base + step * 32'(i);
        r.size = vsew[1:0];
        exp_req.push_back(r);
        elem = $urandom;
        rsp_data_q.push_back(elem);
        for (int b = 0; b < sew; b++) expd[i*sew + b] = elem[b];
      end
      if (vl != 0) begin
        w.vd = vd;
        w.data = expd;
        exp_wr.push_back(w);
      end
      exp_done.push_back(1'b0);
    end
  endtask

  task automatic issue_cmd(input bit strided, input logic [31:0] base, input logic [31:0] stride,
                           input int vl, input logic [2:0] vsew, input logic [4:0] vd, output int acc);
    int t;
    t = 0;
    @(posedge clk); #2;
    ld_valid = 1'b1; ld_strided = strided; ld_base = base; ld_stride = stride;
    ld_vl = VLW'(vl); ld_vsew = vsew; ld_vd = vd;
    @(negedge clk); #1;
    while (!ld_ready && t < 200) begin @(negedge clk); #1; t++; end
    check("cmd_accepted", ld_ready, 1);
    acc = cyc;
    @(posedge clk); #2;
    ld_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin @(negedge clk); #1; t++; end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic run_cmd(input bit strided, input logic [31:0] base, input logic [31:0] stride,
                         input int vl, input logic [2:0] vsew, input logic [4:0] vd,
                         input int l, input int rp, output int acc);
    int d0;
    lat = l;
    rdy_pct = rp;
    expect_cmd(strided, base, stride, vl, vsew, vd);
    d0 = done_cnt;
    issue_cmd(strided, base, stride, vl, vsew, vd, acc);
    wait_done(d0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t, h0, vm, vl, r;
    logic [2:0] vsew;
    logic [31:0] stride;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_ld_ready", ld_ready, 1);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_wr_en", vrf_wr_en, 0);
    check("rst_done", ld_done, 0);
    check("rst_error", ld_error, 0);
    check("rst_wr_data", vrf_wr_data, 0);

    // Unit-stride e32 with immediate ready/response.
    run_cmd(1'b0, 32'h1000, 32'h0, 4, 3'b010, 5'd7, 0, 100, acc);
    // Strided e8 with negative stride.
    run_cmd(1'b1, 32'h10, 32'hFFFF_FFFC, 3, 3'b000, 5'd3, 1, 100, acc);
    // Outstanding cap with slow memory.
    inflight = 0; max_inflight = 0;
    run_cmd(1'b0, 32'h2000, 32'h0, 8, 3'b001, 5'd9, 10, 100, acc);
    check("max_outstanding", max_inflight, 4);
    // vl == 0: completes at N+1 without request or write.
    run_cmd(1'b0, 32'h3000, 32'h0, 0, 3'b010, 5'd1, 1, 100, acc);
    check("vl0_done_cycle", last_done_cyc - acc, 1);
    // Illegal vsew.
    run_cmd(1'b0, 32'h3000, 32'h0, 2, 3'b011, 5'd1, 1, 100, acc);
    check("badsew_done_cycle", last_done_cyc - acc, 1);
    // vl beyond VLEN/SEW at e32.
    run_cmd(1'b0, 32'h3000, 32'h0, 17, 3'b010, 5'd1, 1, 100, acc);
    check("vl17_done_cycle", last_done_cyc - acc, 1);
    // Full e32 register: boundary vl == VLEN/SEW.
    run_cmd(1'b0, 32'h4000, 32'h0, 16, 3'b010, 5'd31, 2, 80, acc);
    // Address wrap.
    run_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 2, 3'b010, 5'd2, 1, 100, acc);
    // Minimum latency: vl=1, response in the issue cycle.
    run_cmd(1'b0, 32'h5000, 32'h0, 1, 3'b010, 5'd4, 0, 100, acc);
    check("minlat_done_cycle", last_done_cyc - acc, 2);

    // Reset mid-load after two handshakes.
    lat = 8; rdy_pct = 100;
    expect_cmd(1'b0, 32'h6000, 32'h0, 4, 3'b010, 5'd5);
    h0 = hs_cnt;
    issue_cmd(1'b0, 32'h6000, 32'h0, 4, 3'b010, 5'd5, acc);
    t = 0;
    while (hs_cnt - h0 < 2 && t < 100) begin @(negedge clk); #1; t++; end
    check("two_issued_before_reset", hs_cnt - h0, 2);
    @(posedge clk); #2;
    reset = 1'b1;
    exp_req.delete(); exp_wr.delete(); exp_done.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk); #1;
    check("post_rst_ready", ld_ready, 1);
    check("post_rst_req_valid", mem_req_valid, 0);
    check("post_rst_done", ld_done, 0);
    t = 0;
    while (due_q.size() != 0 && t < 100) begin @(negedge clk); #1; t++; end
    check("strays_delivered", due_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    check("idle_after_strays", ld_ready, 1);
    rsp_data_q.delete();
    inflight = 0;
    run_cmd(1'b0, 32'h7000, 32'h0, 4, 3'b010, 5'd6, 2, 100, acc);

    // Randomised commands.
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(15);
      vsew = (r == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
      vm = (vsew <= 3'd2) ? (VLEN >> (3 + vsew)) : 16;
      vl = ($urandom_range(7) == 0) ? vm + $urandom_range(1, 3) : $urandom_range(vm);
      stride = 32'($urandom_range(64)) - 32'd32;
      run_cmd(1'($urandom_range(1)), $urandom, stride, vl, vsew, 5'($urandom_range(31)),
              $urandom_range(6), $urandom_range(100, 50), acc);
    end

    repeat (5) @(negedge clk);
    check("exp_req_drained", exp_req.size(), 0);
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_done_drained", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vec_load_sequencer.md
# vec_load_sequencer

Sequences one vector load at a time (unit-stride or strided) into per-element scalar memory requests. It collects the in-order responses into a VLEN-bit staging buffer and writes the assembled register to the vector register file in one beat. It sits between the vector decode/controller stage, which supplies base, stride, vl, vsew and vd, and the data-memory port.

## Interface
- XLEN, 32, scalar/address width; memory response data width
- VLEN, 512, vector register width in bits
- MAX_OUTSTANDING, 4, maximum in-flight memory requests
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  load command valid
- ld_ready  out  1  command accepted when high with ld_valid; high only in IDLE
- ld_strided  in  1  0 = unit-stride (mop 00), 1 = strided (mop 10)
- ld_base  in  XLEN  base address (rs1)
- ld_stride  in  XLEN  byte stride (rs2), two's complement; ignored if unit-stride
- ld_vl  in  $clog2(VLEN/8)+1  element count
- ld_vsew  in  3  000=e8, 001=e16, 010=e32, others illegal
- ld_vd  in  5  destination vector register
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  element byte address
- mem_req_size  out  2  log2(bytes): 0/1/2
- mem_rsp_valid  in  1  in-order response; always accepted, no backpressure
- mem_rsp_data  in  XLEN  element data, right-aligned
- vrf_wr_en  out  1  one-cycle VRF write strobe
- vrf_wr_addr  out  5  = latched vd
- vrf_wr_data  out  VLEN  assembled register
- ld_done  out  1  one-cycle completion pulse
- ld_error  out  1  one-cycle pulse with ld_done on illegal command

## Operation
- States: IDLE, ISSUE, DRAIN, WB, ERR.
- IDLE: ld_ready=1. On ld_valid, latch all command fields, clear the staging buffer to zero (tail = zero-fill), and clear issue_cnt, rsp_cnt and outstanding.
  - vsew illegal or ld_vl > VLEN/SEW → ERR.
  - ld_vl==0 → WB with write suppressed.
  - Otherwise → ISSUE.
- ISSUE: mem_req_valid = (outstanding < MAX_OUTSTANDING).
  - On a handshake, addr_acc += step, issue_cnt++, outstanding++.
  - step = SEW/8 for unit-stride, ld_stride for strided. Addition is modulo 2^XLEN (wraps).
  - First request address = ld_base.
  - When issue_cnt reaches vl (the last handshake) → DRAIN.
- Responses (ISSUE or DRAIN): on mem_rsp_valid, write mem_rsp_data[SEW-1:0] into buffer element rsp_cnt (bits rsp_cnt*SEW +: SEW), then rsp_cnt++ and outstanding--.
- Simultaneous issue and response in one cycle: outstanding unchanged, both counters advance.
- DRAIN: mem_req_valid=0. When rsp_cnt reaches vl → WB.
- WB (one cycle): ld_done=1; vrf_wr_en=1 unless vl==0; vrf_wr_data = buffer; → IDLE.
- ERR (one cycle): ld_done=1, ld_error=1, no request, no write; → IDLE.
- mem_rsp_valid in IDLE, WB or ERR is ignored.
- mem_req_size = vsew[1:0].
- Reset (any state, including mid-load): → IDLE; all counters and outstanding = 0; all outputs 0 except ld_ready=1. Requests in flight at reset are abandoned, and their late responses arrive in IDLE and are ignored.

## Timing
- Command accepted at edge N; first mem_req_valid in cycle N+1.
- With mem_req_ready tied high, one request per cycle until the outstanding cap is reached.
- Minimum latency, vl=1 with a zero-latency response in the issue cycle: accept N, issue N+1, rsp N+1, WB N+2, ld_done in N+2.
- Error and vl==0 commands: ld_done in cycle N+1.
- mem_req_addr and mem_req_size are stable while mem_req_valid is high and not yet accepted.
- ld_ready is low from N+1 until the cycle after ld_done.
- All outputs are registered or decoded from state; no combinational path from mem_rsp_valid to mem_req_valid.

## Structure
- Package vec_lsu_pkg:
  - state enum vls_state_e
  - vsew encodings (VSEW_E8/E16/E32)
  - function sew_bits(vsew)
- Sub-module vec_load_buffer: VLEN-bit staging register with a clear input and an indexed, SEW-width element write port.
- The controller holds the FSM, the address accumulator and the three counters.

## Test plan
- Unit-stride e32, vl=4, base=0x1000, ready/rsp immediate → addrs 0x1000/4/8/C with size 2; vrf_wr_data[127:0] = responses in order; upper bits 0; one vrf_wr_en with vd latched.
- Strided e8, vl=3, base=0x10, stride=-4 → addrs 0x10, 0x0C, 0x08 with size 0; bytes packed into bits [23:0].
- Outstanding cap: vl=8 e16, responses delayed 10 cycles → at most 4 requests before the first response; simultaneous issue and response keeps outstanding constant; done after the 8th response.
- Boundaries:
  - vl=0 → ld_done at N+1, no request, no vrf_wr_en.
  - vsew=011 → ld_done and ld_error at N+1.
  - vl=17 at e32 → error.
- Address wrap: base=0xFFFF_FFFC, e32, vl=2 → addrs 0xFFFF_FFFC then 0x0000_0000.
- Reset asserted in ISSUE after 2 of 4 requests → next cycle IDLE, ld_ready=1, a stray response is ignored, and a fresh command completes correctly.
